// File: rtl/simple_spi_slave_if.sv
// simple_spi_slave_if: SPI bus pins shared by a master and simple_spi_slave
interface simple_spi_slave_if;
    logic spi_cs;
    logic spi_clk;
    logic spi_mosi;
    logic spi_miso;
    modport master (output spi_cs, output spi_clk, output spi_mosi, input spi_miso);
    modport slave (input spi_cs, input spi_clk, input spi_mosi, output spi_miso);
endinterface

// File: rtl/simple_spi_slave.sv
// simple_spi_slave: oversampled SPI responder for all CPOL/CPHA modes with a word handshake.
// Define SIMPLE_SPI_SLAVE_MISO_TRISTATE_EN to release spi_miso (z) while idle.
module simple_spi_slave #(
    parameter int WORDWIDTH = 4,
    parameter int SYNCHRONIZE_INPUTS_FOR_CLKS = 3
) (
    input  logic                 system_clk,
    input  logic                 system_rst_n,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic                 msb_first,
    input  logic [WORDWIDTH-1:0] data_tx,
    output logic                 word_load,
    output logic                 word_completed,
    output logic [WORDWIDTH-1:0] data_rx,
    output logic                 xfer_aborted,
    output logic                 xfer_active,
    simple_spi_slave_if.slave    spi
);
    localparam int S = SYNCHRONIZE_INPUTS_FOR_CLKS;
    localparam int CW = $clog2(WORDWIDTH);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state;
    logic [S-1:0] cs_s, clk_s, mosi_s;
    logic cs_q, clk_q, skip, miso_q;
    logic [CW-1:0] cnt;
    logic [WORDWIDTH-1:0] tx_sr, rx_sr, rx_next;
    logic cs_rise, cs_fall, lead, trail, sample, shift, last;
    function automatic logic first_bit(input logic [WORDWIDTH-1:0] v, input logic msb);
        return msb ? v[WORDWIDTH-1] : v[0];
    endfunction
    function automatic logic [WORDWIDTH-1:0] shifted(input logic [WORDWIDTH-1:0] v, input logic msb);
        return msb ? v << 1 : v >> 1;
    endfunction
    assign cs_rise = cs_s[S-1] & ~cs_q;
    assign cs_fall = ~cs_s[S-1] & cs_q;
    // polarity folded into both sides so a cpol change alone never looks like an edge
    assign lead = (clk_s[S-1] ^ cpol) & ~(clk_q ^ cpol);
    assign trail = ~(clk_s[S-1] ^ cpol) & (clk_q ^ cpol);
    assign sample = cpha ? trail : lead;
    assign shift = cpha ? lead : trail;
    assign last = cnt == CW'(WORDWIDTH - 1);
    assign rx_next = msb_first ? {rx_sr[WORDWIDTH-2:0], mosi_s[S-1]} : {mosi_s[S-1], rx_sr[WORDWIDTH-1:1]};
    always_ff @(posedge system_clk or negedge system_rst_n)
        if (!system_rst_n) begin
            cs_s <= '0;
            clk_s <= '0;
            mosi_s <= '0;
            cs_q <= 1'b0;
            clk_q <= 1'b0;
            state <= IDLE;
            cnt <= '0;
            skip <= 1'b0;
            miso_q <= 1'b0;
            tx_sr <= '0;
            rx_sr <= '0;
            data_rx <= '0;
            word_load <= 1'b0;
            word_completed <= 1'b0;
            xfer_aborted <= 1'b0;
            xfer_active <= 1'b0;
        end else begin
            cs_s <= {cs_s[S-2:0], spi.spi_cs};
            clk_s <= {clk_s[S-2:0], spi.spi_clk};
            mosi_s <= {mosi_s[S-2:0], spi.spi_mosi};
            cs_q <= cs_s[S-1];
            clk_q <= clk_s[S-1];
            word_load <= 1'b0;
            word_completed <= 1'b0;
            xfer_aborted <= 1'b0;
            if (state == IDLE) begin
                if (cs_rise) begin
                    state <= ACTIVE;
                    xfer_active <= 1'b1;
                    word_load <= 1'b1;
                    cnt <= '0;
                    skip <= 1'b0;
                    tx_sr <= cpha ? data_tx : shifted(data_tx, msb_first);
                    if (!cpha) miso_q <= first_bit(data_tx, msb_first);
                end
            end else if (cs_fall) begin
                state <= IDLE;
                xfer_active <= 1'b0;
                miso_q <= 1'b0;
                cnt <= '0;
                xfer_aborted <= cnt != '0;
            end else begin
                if (sample) begin
                    rx_sr <= rx_next;
                    cnt <= last ? '0 : cnt + 1'b1;
                    // cpha=0 drives the next word's first bit now, so its next trailing edge must not shift
                    if (last) begin
                        data_rx <= rx_next;
                        word_completed <= 1'b1;
                        word_load <= 1'b1;
                        skip <= ~cpha;
                        tx_sr <= cpha ? data_tx : shifted(data_tx, msb_first);
                        if (!cpha) miso_q <= first_bit(data_tx, msb_first);
                    end
                end
                if (shift) begin
                    if (skip) skip <= 1'b0;
                    else begin
                        miso_q <= first_bit(tx_sr, msb_first);
                        tx_sr <= shifted(tx_sr, msb_first);
                    end
                end
            end
        end
`ifdef SIMPLE_SPI_SLAVE_MISO_TRISTATE_EN
    assign spi.spi_miso = (state == ACTIVE) ? miso_q : 1'bz;
`else
    assign spi.spi_miso = miso_q;
`endif
endmodule

// File: tb/tb_simple_spi_slave.sv
// tb_simple_spi_slave: bench-driven SPI master exercising simple_spi_slave in all 8 modes,
// with a latency/queue model of the slave checked every cycle.
`timescale 1ns/1ps
module tb_simple_spi_slave;
    localparam int W = 4;
    localparam int S = 3;
    localparam int H = 8;
    logic system_clk = 1'b0;
    logic system_rst_n;
    logic cpol, cpha, msb_first;
    logic [W-1:0] data_tx, data_rx;
    logic word_load, word_completed, xfer_aborted, xfer_active;
    logic idle_miso;
    int n_chk, n_fail, load_cnt, abort_cnt, exp_loads, exp_aborts, tx_base;
    logic [15:0] tx_words;
    logic [S:0] hist;
    logic [W-1:0] model_rx;
    logic [W-1:0] exp_rx[$];
    logic [11:0] rx_m;
    simple_spi_slave_if bus();
    simple_spi_slave #(.WORDWIDTH(W), .SYNCHRONIZE_INPUTS_FOR_CLKS(S)) dut (
        .system_clk(system_clk),
        .system_rst_n(system_rst_n),
        .cpol(cpol),
        .cpha(cpha),
        .msb_first(msb_first),
        .data_tx(data_tx),
        .word_load(word_load),
        .word_completed(word_completed),
        .data_rx(data_rx),
        .xfer_aborted(xfer_aborted),
        .xfer_active(xfer_active),
        .spi(bus)
    );
    always #5 system_clk = ~system_clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic ticks(input int n);
        repeat (n) @(negedge system_clk);
    endtask
    // slave outputs follow spi_cs with S+1 clocks of latency; received words come from a queue
    task automatic compare_loop();
        forever begin
            @(negedge system_clk);
            if (!system_rst_n) begin
                model_rx = '0;
                exp_rx.delete();
            end else begin
                chk("xfer_active", xfer_active, hist[S]);
                if (!hist[S]) chk("idle_miso", bus.spi_miso, idle_miso);
                if (word_load) load_cnt++;
                if (xfer_aborted) abort_cnt++;
                if (word_completed) begin
                    if (exp_rx.size() == 0) chk("unexpected_completion", 1, 0);
                    else model_rx = exp_rx.pop_front();
                end
                chk("data_rx", data_rx, model_rx);
            end
            begin
                int i;
                i = load_cnt - tx_base;
                data_tx = (i >= 0 && i < 4) ? tx_words[4*i +: 4] : '0;
            end
        end
    endtask
    task automatic hist_loop();
        forever begin
            @(posedge system_clk);
            hist = system_rst_n ? {hist[S-1:0], bus.spi_cs} : '0;
        end
    endtask
    task automatic xfer(input int nb, input logic [11:0] mo, input logic [15:0] stx, output logic [11:0] mi);
        tx_words = stx;
        tx_base = load_cnt;
        exp_loads += 1 + nb / W;
        if (nb % W != 0) exp_aborts++;
        mi = '0;
        bus.spi_cs = 1'b1;
        ticks(H);
        for (int b = 0; b < nb; b++) begin
            int k;
            k = W * (b / W) + (msb_first ? W - 1 - b % W : b % W);
            if (!cpha) begin
                bus.spi_mosi = mo[k];
                bus.spi_clk = ~cpol;
                mi[k] = bus.spi_miso;
                if (b % W == W - 1) exp_rx.push_back(mo[W*(b/W) +: W]);
            end else begin
                bus.spi_clk = ~cpol;
                bus.spi_mosi = mo[k];
            end
            ticks(H);
            bus.spi_clk = cpol;
            if (cpha) begin
                mi[k] = bus.spi_miso;
                if (b % W == W - 1) exp_rx.push_back(mo[W*(b/W) +: W]);
            end
            ticks(H);
        end
        bus.spi_cs = 1'b0;
        ticks(2 * H);
        chk("word_loads", load_cnt, exp_loads);
        chk("aborts", abort_cnt, exp_aborts);
        chk("pending_words", exp_rx.size(), 0);
    endtask
    initial begin
`ifdef SIMPLE_SPI_SLAVE_MISO_TRISTATE_EN
        idle_miso = 1'bz;
`else
        idle_miso = 1'b0;
`endif
        system_rst_n = 1'b0;
        {cpol, cpha, msb_first} = 3'b000;
        bus.spi_cs = 1'b0;
        bus.spi_clk = 1'b0;
        bus.spi_mosi = 1'b0;
        data_tx = '0;
        tx_words = '0;
        tx_base = 0;
        hist = '0;
        model_rx = '0;
        fork
            compare_loop();
            hist_loop();
        join_none
        ticks(3);
        chk("rst_data_rx", data_rx, 4'h0);
        chk("rst_xfer_active", xfer_active, 1'b0);
        chk("rst_pulses", {word_load, word_completed, xfer_aborted}, 3'b000);
        chk("rst_miso", bus.spi_miso, idle_miso);
        system_rst_n = 1'b1;
        ticks(H);
        for (int m = 0; m < 8; m++) begin
            {cpol, cpha, msb_first} = 3'(m);
            bus.spi_clk = cpol;
            ticks(H);
            xfer(4, 12'h006, 16'h000A, rx_m);
            chk("single_miso", rx_m[3:0], 4'hA);
            chk("single_rx", data_rx, 4'h6);
            xfer(2, 12'h00F, 16'h0005, rx_m);
            chk("abort_rx_kept", data_rx, 4'h6);
            xfer(4, 12'h003, 16'h0009, rx_m);
            chk("after_abort_miso", rx_m[3:0], 4'h9);
            chk("after_abort_rx", data_rx, 4'h3);
            for (int t = 0; t < 6; t++) begin
                bus.spi_clk = ~bus.spi_clk;
                bus.spi_mosi = t[0];
                ticks(H);
            end
            bus.spi_clk = cpol;
            ticks(H);
            chk("idle_loads", load_cnt, exp_loads);
            chk("idle_aborts", abort_cnt, exp_aborts);
            chk("idle_active", xfer_active, 1'b0);
            tx_words = 16'h0007;
            tx_base = load_cnt;
            exp_loads++;
            bus.spi_cs = 1'b1;
            ticks(H);
            bus.spi_clk = ~cpol;
            bus.spi_mosi = 1'b1;
            ticks(H);
            bus.spi_clk = cpol;
            ticks(2);
            #2 system_rst_n = 1'b0;
            #1;
            chk("midword_rst_data_rx", data_rx, 4'h0);
            chk("midword_rst_active", xfer_active, 1'b0);
            chk("midword_rst_pulses", {word_load, word_completed, xfer_aborted}, 3'b000);
            chk("midword_rst_miso", bus.spi_miso, idle_miso);
            bus.spi_cs = 1'b0;
            ticks(3);
            system_rst_n = 1'b1;
            ticks(H);
            xfer(4, 12'h00E, 16'h000E, rx_m);
            chk("post_rst_miso", rx_m[3:0], 4'hE);
            chk("post_rst_rx", data_rx, 4'hE);
            xfer(12, 12'h0F0, 16'h0C5A, rx_m);
            chk("burst_miso", rx_m, 12'hC5A);
            chk("burst_rx", data_rx, 4'h0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
